// File: rtl/mpq_pkg.sv
// mpq_pkg: shared types for the MPQ host driver (command codes, FSM states, FIFO entry)
package mpq_pkg;
  typedef enum logic [2:0] {
    BUILD   = 3'b000,
    EXTRACT = 3'b001,
    INC     = 3'b010,
    INSERT  = 3'b011,
    WRITE   = 3'b100
  } cmd_t;
  typedef enum logic [2:0] {LOAD, CMD, WAIT_DONE, DUMP, FIN} state_t;
  typedef struct packed {
    logic       is_cmd;
    logic [7:0] data;
    cmd_t       cmd;
    logic [7:0] index;
    logic [7:0] value;
  } fifo_entry_t;
endpackage

// File: rtl/mpq_src_fifo.sv
// mpq_src_fifo: synchronous source FIFO; pointers carry one extra wrap bit for full/empty
module mpq_src_fifo import mpq_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t din,
  output fifo_entry_t dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  fifo_entry_t mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/mpq_host.sv
// mpq_host: feeds MPQ from a buffered data/command stream, shadows its RAM writes, dumps them on done.
// Optional MPQ_HOST_ERR_EN: drop mis-phased items and flag err; otherwise err is tied low.
module mpq_host import mpq_pkg::*; #(
  parameter int DATA_NUM   = 12,
  parameter int CMD_NUM    = 12,
  parameter int RES_NUM    = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       src_valid,
  output logic       src_ready,
  input  logic       src_is_cmd,
  input  logic [7:0] src_data,
  input  logic [2:0] src_cmd,
  input  logic [7:0] src_index,
  input  logic [7:0] src_value,
  output logic       data_valid,
  output logic [7:0] data,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic [7:0] index,
  output logic [7:0] value,
  input  logic       busy,
  input  logic       RAM_valid,
  input  logic [7:0] RAM_A,
  input  logic [7:0] RAM_D,
  input  logic       done,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_addr,
  output logic [7:0] res_data,
  output logic       finished,
  output logic       err
);
  localparam int DW = $clog2(DATA_NUM + 1);
  localparam int CW = $clog2(CMD_NUM + 1);
  localparam int RW = $clog2(RES_NUM);
  localparam logic [DW-1:0] D_LAST = DW'(DATA_NUM - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CMD_NUM - 1);
  localparam logic [7:0] R_LAST = 8'(RES_NUM - 1);
  localparam logic [7:0] R_NUM = 8'(RES_NUM);
  state_t state, state_nx;
  fifo_entry_t din, head;
  logic full, empty, push, pop, do_data, do_cmd, ok_data, ok_cmd, rise, xfer, done_q;
  logic [DW-1:0] dcnt;
  logic [CW-1:0] ccnt;
  logic [7:0] raddr;
  logic [7:0] shadow [RES_NUM];
  assign src_ready = !full && state != FIN;
  assign push = src_valid && src_ready;
  assign din = '{src_is_cmd, src_data, cmd_t'(src_cmd), src_index, src_value};
  assign rise = done && !done_q;
  assign xfer = state == DUMP && res_ready;
  assign res_valid = state == DUMP;
  assign res_addr = state == DUMP ? raddr : '0;
  assign res_data = state == DUMP ? shadow[raddr[RW-1:0]] : '0;
  assign finished = state == FIN;
`ifdef MPQ_HOST_ERR_EN
  assign ok_data = !head.is_cmd;
  assign ok_cmd = head.is_cmd;
  always_ff @(posedge clk or negedge rst)
    if (!rst) err <= 1'b0;
    else if ((pop && !do_data && !do_cmd) || (state == FIN && src_valid)) err <= 1'b1;
`else
  logic unused_is_cmd;
  assign unused_is_cmd = head.is_cmd;
  assign ok_data = 1'b1;
  assign ok_cmd = 1'b1;
  assign err = 1'b0;
`endif
  mpq_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= LOAD;
    else state <= state_nx;
  // cmd_valid high means a command went out last cycle, which enforces the busy-rise gap
  always_comb begin
    state_nx = state;
    do_data = 1'b0;
    do_cmd = 1'b0;
    pop = 1'b0;
    case (state)
      LOAD: begin
        pop = !empty;
        do_data = !empty && ok_data;
        state_nx = do_data && dcnt == D_LAST ? CMD : LOAD;
      end
      CMD: begin
        do_cmd = !empty && ok_cmd && !busy && !cmd_valid;
        pop = do_cmd || (!empty && !ok_cmd);
        state_nx = do_cmd && ccnt == C_LAST ? WAIT_DONE : CMD;
      end
      WAIT_DONE: state_nx = rise ? DUMP : WAIT_DONE;
      DUMP: state_nx = xfer && raddr == R_LAST ? FIN : DUMP;
      default: state_nx = state;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dcnt <= '0;
      ccnt <= '0;
      raddr <= '0;
      done_q <= 1'b0;
      data_valid <= 1'b0;
      data <= '0;
      cmd_valid <= 1'b0;
      cmd <= '0;
      index <= '0;
      value <= '0;
    end else begin
      done_q <= done;
      data_valid <= do_data;
      cmd_valid <= do_cmd;
      if (do_data) begin
        data <= head.data;
        dcnt <= dcnt + 1'b1;
      end
      if (do_cmd) begin
        cmd <= head.cmd;
        index <= head.index;
        value <= head.value;
        ccnt <= ccnt + 1'b1;
      end
      if (xfer) raddr <= raddr + 1'b1;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) shadow <= '{default: '0};
    else if (RAM_valid && RAM_A < R_NUM) shadow[RAM_A[RW-1:0]] <= RAM_D;
endmodule

// File: tb/tb_mpq_host.sv
// tb_mpq_host: scoreboard bench for mpq_host (load, busy gating, full FIFO, snoop, dump, reset)
module tb_mpq_host;
  import mpq_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic src_valid = 1'b0, src_ready, src_is_cmd = 1'b0;
  logic [7:0] src_data = '0, src_index = '0, src_value = '0;
  logic [2:0] src_cmd = '0;
  logic data_valid, cmd_valid, res_valid, finished, err;
  logic [7:0] data, index, value, res_addr, res_data;
  logic [2:0] cmd;
  logic busy = 1'b0, RAM_valid = 1'b0, done = 1'b0, res_ready = 1'b0;
  logic [7:0] RAM_A = '0, RAM_D = '0;
  int n_run = 0, n_fail = 0;
  logic [7:0] dq [$];
  logic [18:0] cq [$];
  logic [7:0] exp_sh [13];
  int cmd_seen = 0, rx_idx = 0;
  logic prev_cv = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_addr = '0;

  mpq_host dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .src_is_cmd(src_is_cmd), .src_data(src_data), .src_cmd(src_cmd),
    .src_index(src_index), .src_value(src_value), .data_valid(data_valid),
    .data(data), .cmd_valid(cmd_valid), .cmd(cmd), .index(index), .value(value),
    .busy(busy), .RAM_valid(RAM_valid), .RAM_A(RAM_A), .RAM_D(RAM_D), .done(done),
    .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr),
    .res_data(res_data), .finished(finished), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // call from just after a rising edge; returns just after the accepting edge
  task automatic push(input logic c, input logic [7:0] d, input logic [2:0] k,
                      input logic [7:0] i, input logic [7:0] v);
    int t = 0;
    src_valid = 1'b1;
    src_is_cmd = c;
    src_data = d;
    src_cmd = k;
    src_index = i;
    src_value = v;
    @(negedge clk);
    while (!src_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", src_ready, 1);
    @(posedge clk);
    #1;
    src_valid = 1'b0;
  endtask

  task automatic push_cmd(input int k);
    logic [2:0] c;
    c = 3'(k % 5);
    cq.push_back({c, 8'(k * 3), 8'(8'hA0 + k)});
    push(1'b1, 8'hEE, c, 8'(k * 3), 8'(8'hA0 + k));
  endtask

  task automatic wait_cmds(input int target);
    int t = 0;
    while (cmd_seen < target && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("cmd_count", cmd_seen, target);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (data_valid) begin
        check("data_pending", dq.size() != 0, 1);
        if (dq.size() != 0) check("data", data, dq.pop_front());
      end
      if (cmd_valid) begin
        check("cmd_gap", prev_cv, 0);
        check("cmd_pending", cq.size() != 0, 1);
        if (cq.size() != 0) check("cmd", {cmd, index, value}, cq.pop_front());
        cmd_seen++;
      end
      if (prev_stall) check("res_hold", {res_valid, res_addr}, {1'b1, prev_addr});
      if (res_valid && res_ready) begin
        check("res_addr", res_addr, rx_idx);
        check("res_in_range", rx_idx < 13, 1);
        if (rx_idx < 13) check("res_data", res_data, exp_sh[rx_idx]);
        rx_idx++;
      end
      prev_cv = cmd_valid;
      prev_stall = res_valid && !res_ready;
      prev_addr = res_addr;
    end else begin
      prev_cv = 1'b0;
      prev_stall = 1'b0;
    end
  end

  initial begin
    int n_data;
    logic [7:0] wa [4];
    logic [7:0] wd [4];
    int t;
    wa = '{8'h02, 8'h20, 8'h0C, 8'h0D};
    wd = '{8'h9C, 8'h55, 8'hA5, 8'h77};
    foreach (exp_sh[i]) exp_sh[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_src_ready", src_ready, 1);
    check("rst_data_valid", data_valid, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_finished", finished, 0);
    check("rst_err", err, 0);
    check("rst_outs", {data, cmd, index, value, res_addr, res_data}, 0);
    sync();
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      dq.push_back(8'(i));
      push(1'b0, 8'(i), 3'd7, 8'hFF, 8'hFF);
    end
    busy = 1'b1;
    done = 1'b1;
    for (int k = 0; k < 4; k++) push_cmd(k);
    @(negedge clk);
    check("full_ready", src_ready, 0);
    check("load_drained", dq.size(), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_block", cmd_valid, 0);
    end
    sync();
    busy = 1'b0;
    @(negedge clk);
    check("issue_early", cmd_valid, 0);
    @(negedge clk);
    check("issue_after_busy", cmd_valid, 1);
    sync();
    for (int k = 4; k < 12; k++) push_cmd(k);
    for (int i = 0; i < 4; i++) begin
      RAM_valid = 1'b1;
      RAM_A = wa[i];
      RAM_D = wd[i];
      if (wa[i] < 13) exp_sh[wa[i]] = wd[i];
      sync();
    end
    RAM_valid = 1'b0;
    wait_cmds(12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_dump_on_high_done", res_valid, 0);
    end
    sync();
    done = 1'b0;
    sync();
    done = 1'b1;
    t = 0;
    while (!finished && t < 200) begin
      sync();
      res_ready = ~res_ready;
      t++;
    end
    check("finished", finished, 1);
    check("xfer_count", rx_idx, 13);
    @(negedge clk);
    check("fin_src_ready", src_ready, 0);
    check("fin_res_valid", res_valid, 0);
    check("fin_err", err, 0);
    sync();
    rst = 1'b0;
    #2;
    check("async_finished", finished, 0);
    check("async_src_ready", src_ready, 1);
    sync();
    rst = 1'b1;
    res_ready = 1'b0;
    done = 1'b0;
    dq.delete();
    cq.delete();
    cmd_seen = 0;
`ifdef MPQ_HOST_ERR_EN
    push(1'b1, 8'h5A, WRITE, 8'h01, 8'h02);
    @(negedge clk);
    @(negedge clk);
    check("err_set", err, 1);
    sync();
    n_data = 12;
`else
    dq.push_back(8'h5A);
    push(1'b1, 8'h5A, WRITE, 8'h01, 8'h02);
    n_data = 11;
`endif
    for (int i = 0; i < n_data; i++) begin
      dq.push_back(8'(8'h30 + i));
      push(1'b0, 8'(8'h30 + i), 3'd0, 8'h00, 8'h00);
    end
    push_cmd(5);
    wait_cmds(1);
    check("reload_drained", dq.size(), 0);
    sync();
    busy = 1'b1;
    push(1'b1, 8'h00, INSERT, 8'h44, 8'h55);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valids", {data_valid, cmd_valid, res_valid, finished}, 0);
    check("mid_rst_outs", {data, cmd, index, value}, 0);
    check("mid_rst_ready", src_ready, 1);
    check("mid_rst_err", err, 0);
    sync();
    rst = 1'b1;
    busy = 1'b0;
    cq.delete();
    dq.push_back(8'h77);
    push(1'b0, 8'h77, 3'd0, 8'h00, 8'h00);
    repeat (5) @(negedge clk);
    check("dq_left", dq.size(), 0);
    check("cq_left", cq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
